// File: rtl/alu32.sv
// 32-bit ALU: add/sub, bitwise logic and barrel shifts computed combinationally,
// with the result and carry/shift-out flag registered on the rising clock edge.
module alu32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  control,
    output logic [31:0] dout,
    output logic        cout
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    logic [4:0]  sh;
    logic        is_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic [32:0] sll_ext;
    logic [32:0] srl_ext;
    logic [32:0] sra_ext;
    logic [31:0] next_dout;
    logic        next_cout;

    assign sh     = b[4:0];
    assign is_sub = (control == OP_SUB);

    // Subtract is a + ~b + 1; the carry-in supplies the +1, so cout=1 means no borrow.
    assign b_eff = is_sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};

    // One extra bit beyond the word catches the last bit shifted out; it stays
    // zero for a shift of 0.
    assign sll_ext = {1'b0, a} << sh;
    assign srl_ext = {a, 1'b0} >> sh;
    assign sra_ext = $unsigned($signed({a, 1'b0}) >>> sh);

    always_comb begin
        next_dout = 32'd0;
        next_cout = 1'b0;
        case (op_e'(control))
            OP_ADD, OP_SUB: begin
                next_dout = sum[31:0];
                next_cout = sum[32];
            end
            OP_AND: next_dout = a & b;
            OP_OR:  next_dout = a | b;
            OP_XOR: next_dout = a ^ b;
            OP_SLL: begin
                next_dout = sll_ext[31:0];
                next_cout = sll_ext[32];
            end
            OP_SRL: begin
                next_dout = srl_ext[32:1];
                next_cout = srl_ext[0];
            end
            OP_SRA: begin
                next_dout = sra_ext[32:1];
                next_cout = sra_ext[0];
            end
            default: begin
                next_dout = 32'd0;
                next_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 32'd0;
            cout <= 1'b0;
        end else begin
            dout <= next_dout;
            cout <= next_cout;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vector table, reset sequences,
// a back-to-back pattern sweep over all opcodes and randomized operations.
module tb_alu32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  control;
  logic [31:0] dout;
  logic        cout;

  int n_checks;
  int n_fail;

  logic [32:0] exp_q[$];

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] dout;
    logic        cout;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  alu32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .control (control),
    .dout    (dout),
    .cout    (cout)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: straight from the operation rules using wide arithmetic
  function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    int              sh;
    longint unsigned s;
    logic [31:0]     r;
    logic            co;
    sh = int'(y[4:0]);
    r  = 32'd0;
    co = 1'b0;
    case (c)
      3'd0: begin
        s  = longint'(x) + longint'(y);
        r  = s[31:0];
        co = (s > 64'h0000_0000_FFFF_FFFF);
      end
      3'd1: begin
        r  = x - y;
        co = (x >= y);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        r  = x << sh;
        co = (sh == 0) ? 1'b0 : x[32 - sh];
      end
      3'd6: begin
        r  = x >> sh;
        co = (sh == 0) ? 1'b0 : x[sh - 1];
      end
      default: begin
        r  = $unsigned($signed(x) >>> sh);
        co = (sh == 0) ? 1'b0 : x[sh - 1];
      end
    endcase
    return {co, r};
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got cout=%0b dout=%08h, want cout=%0b dout=%08h",
               name, got[32], got[31:0], want[32], want[31:0]);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    control = c;
    a       = x;
    b       = y;
  endtask

  task automatic drive_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    drive(c, x, y);
    exp_q.push_back(model(c, x, y));
  endtask

  // scoreboard: one result per edge, compared just after the edge
  task automatic check_next(input string name);
    logic [32:0] want;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = exp_q.pop_front();
      check(name, {cout, dout}, want);
    end
  endtask

  task automatic fill_vecs();
    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[1]  = '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[2]  = '{3'd1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1};
    vecs[3]  = '{3'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
    vecs[4]  = '{3'd1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[5]  = '{3'd2, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'h00F0_F00F, 1'b0};
    vecs[6]  = '{3'd3, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'hFFF0_FFFF, 1'b0};
    vecs[7]  = '{3'd4, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'hFF00_0FF0, 1'b0};
    vecs[8]  = '{3'd5, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1};
    vecs[9]  = '{3'd6, 32'h8000_0003, 32'h0000_0001, 32'h4000_0001, 1'b1};
    vecs[10] = '{3'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0};
    vecs[11] = '{3'd5, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{3'd6, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{3'd7, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{3'd5, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0};
    vecs[15] = '{3'd7, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0};
    vecs[16] = '{3'd6, 32'h4000_0000, 32'h0000_001F, 32'h0000_0000, 1'b1};
    vecs[17] = '{3'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(3'd0, 32'h1111_1111, 32'h2222_2222);
    fill_vecs();

    // outputs held at zero through reset, including across clock edges
    #1;
    check("reset_initial", {cout, dout}, 33'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {cout, dout}, 33'd0);

    // release mid-cycle: outputs stay 0 until the first edge captures inputs
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd0, 32'h0000_0001, 32'h0000_0002);
    #1;
    check("release_before_edge", {cout, dout}, 33'd0);
    @(posedge clk);
    #1;
    check("release_first_edge", {cout, dout}, {1'b0, 32'h0000_0003});

    // inputs changing between edges leave the registered outputs alone
    @(negedge clk);
    drive(3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F);
    #2;
    check("hold_between_edges", {cout, dout}, {1'b0, 32'h0000_0003});

    // directed table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {cout, dout}, {vecs[i].cout, vecs[i].dout});
    end

    // asynchronous reset mid-cycle with nonzero output discards the pending result
    @(negedge clk);
    drive(3'd0, 32'h8000_0000, 32'h8000_0001);
    @(posedge clk);
    #1;
    check("pre_async_reset", {cout, dout}, {1'b1, 32'h0000_0001});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", {cout, dout}, 33'd0);
    @(posedge clk);
    #1;
    check("async_reset_over_edge", {cout, dout}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd1, 32'h0000_0005, 32'h0000_0007);
    #1;
    check("async_release_hold", {cout, dout}, 33'd0);
    @(posedge clk);
    #1;
    check("async_release_capture", {cout, dout}, {1'b0, 32'hFFFF_FFFE});

    // back-to-back sweep: all opcodes on consecutive edges over pattern operands
    for (int msb = 0; msb < 16; msb++) begin
      for (int lsb = 0; lsb < 16; lsb++) begin
        logic [23:0] mid;
        logic [31:0] pa;
        logic [31:0] pb;
        mid = 24'($urandom);
        pa  = {4'(msb), mid, 4'(lsb)};
        pb  = {4'(lsb), ~mid, 4'(msb)};
        for (int c = 0; c < 8; c++) begin
          fork
            drive_op(3'(c), pa, pb);
            check_next($sformatf("sweep_m%0d_l%0d_c%0d", msb, lsb, c));
          join
        end
      end
    end

    // randomized operations, including small shift amounts and edge operands
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = {27'($urandom), 5'($urandom_range(0, 31))};
        1: ra = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
        2: rb = ra;
        default: ;
      endcase
      fork
        drive_op(3'($urandom_range(0, 7)), ra, rb);
        check_next($sformatf("rand%0d", i));
      join
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
